// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and helpers for the multi-port register file.
//   - DEFAULT_* : default geometry of the register file
//   - ZERO_REG  : index of the hardwired-zero register
//   - clog2()   : address width for a given depth (usable in parameters)
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_DEPTH  = 32;
    localparam int DEFAULT_NUM_RD = 2;
    localparam int DEFAULT_NUM_WR = 1;
    localparam int ZERO_REG       = 0;

    // Smallest n such that 2**n >= value (value >= 1).
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   Per-register busy bits used by the issue stage to detect operands that
//   are still waiting for a writeback.
//
//   Ports
//     clock           in  rising-edge clock
//     ctrl_reset_n    in  asynchronous active-low reset (clears all busy bits)
//     ctrl_writeEn    in  per-write-port enable   (NUM_WR)
//     ctrl_writeReg   in  write addresses         (NUM_WR*AW)
//     ctrl_reserveEn  in  mark ctrl_reserveReg busy
//     ctrl_reserveReg in  register to reserve     (AW)
//     ctrl_readReg    in  read addresses          (NUM_RD*AW)
//     status_busy     out busy bit per read port  (NUM_RD), combinational
//     status_anyBusy  out OR of all stored busy bits
//
//   Build option: WR_BYPASS_EN -- a read port whose register is being
//   written this cycle (and not re-reserved) reports not-busy, matching the
//   bypassed read data.
// ---------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int NUM_WR = DEFAULT_NUM_WR,
    parameter int NUM_RD = DEFAULT_NUM_RD,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 ctrl_reset_n,
    input  logic [NUM_WR-1:0]    ctrl_writeEn,
    input  logic [NUM_WR*AW-1:0] ctrl_writeReg,
    input  logic                 ctrl_reserveEn,
    input  logic [AW-1:0]        ctrl_reserveReg,
    input  logic [NUM_RD*AW-1:0] ctrl_readReg,
    output logic [NUM_RD-1:0]    status_busy,
    output logic                 status_anyBusy
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Writes clear first, then a reserve sets: a reserve in the same cycle
    // as the write names a newer producer, so it must win.
    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (ctrl_writeEn[p]) begin
                busy_d[ctrl_writeReg[p*AW +: AW]] = 1'b0;
            end
        end
        if (ctrl_reserveEn) begin
            busy_d[ctrl_reserveReg] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        status_busy = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            logic [AW-1:0] ra;
            logic          b;
            ra = ctrl_readReg[r*AW +: AW];
            b  = busy_q[ra];
`ifdef WR_BYPASS_EN
            begin
                logic written;
                written = 1'b0;
                for (int p = 0; p < NUM_WR; p++) begin
                    if (ctrl_writeEn[p] && (ctrl_writeReg[p*AW +: AW] == ra)) begin
                        written = 1'b1;
                    end
                end
                // The reader sees the bypassed value, so the operand is ready
                // unless this same cycle also re-reserves the register.
                if (written && !(ctrl_reserveEn && (ctrl_reserveReg == ra))) begin
                    b = 1'b0;
                end
            end
`endif
            status_busy[r] = b;
        end
    end

    assign status_anyBusy = |busy_q;

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   Parametrised multi-port register file with register 0 hardwired to zero
//   and a per-register busy scoreboard. Sits between decode (read/reserve)
//   and writeback (write).
//
//   Ports
//     clock           in  rising-edge clock
//     ctrl_reset_n    in  asynchronous active-low reset (data and busy -> 0)
//     ctrl_writeEn    in  per-port write enable          (NUM_WR)
//     ctrl_writeReg   in  write addresses, port p at [p*AW +: AW]
//     data_writeReg   in  write data, port p at [p*WIDTH +: WIDTH]
//     ctrl_readReg    in  read addresses                 (NUM_RD*AW)
//     data_readReg    out read data, combinational       (NUM_RD*WIDTH)
//     ctrl_reserveEn  in  mark ctrl_reserveReg busy
//     ctrl_reserveReg in  register to reserve            (AW)
//     status_busy     out busy bit of the register on each read port
//     status_anyBusy  out OR of all busy bits
//
//   Build option: WR_BYPASS_EN -- a read of a register being written in the
//   same cycle returns the incoming write data (winning port on a collision).
//   Without it the read returns the stored value; the new value is visible
//   from the cycle after the edge.
// ---------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int NUM_RD = DEFAULT_NUM_RD,
    parameter int NUM_WR = DEFAULT_NUM_WR,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    ctrl_reset_n,
    input  logic [NUM_WR-1:0]       ctrl_writeEn,
    input  logic [NUM_WR*AW-1:0]    ctrl_writeReg,
    input  logic [NUM_WR*WIDTH-1:0] data_writeReg,
    input  logic [NUM_RD*AW-1:0]    ctrl_readReg,
    output logic [NUM_RD*WIDTH-1:0] data_readReg,
    input  logic                    ctrl_reserveEn,
    input  logic [AW-1:0]           ctrl_reserveReg,
    output logic [NUM_RD-1:0]       status_busy,
    output logic                    status_anyBusy
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Ports are applied in ascending order so the highest-numbered port wins
    // an address collision. Register 0 is never updated and stays at its
    // reset value of zero.
    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (ctrl_writeEn[p] && (ctrl_writeReg[p*AW +: AW] != AW'(ZERO_REG))) begin
                mem_d[ctrl_writeReg[p*AW +: AW]] = data_writeReg[p*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        data_readReg = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            logic [AW-1:0]    ra;
            logic [WIDTH-1:0] val;
            ra  = ctrl_readReg[r*AW +: AW];
            val = mem_q[ra];
`ifdef WR_BYPASS_EN
            // Same ascending order as the write path so the bypass returns
            // the winning port's data.
            for (int p = 0; p < NUM_WR; p++) begin
                if (ctrl_writeEn[p] && (ctrl_writeReg[p*AW +: AW] == ra)) begin
                    val = data_writeReg[p*WIDTH +: WIDTH];
                end
            end
`endif
            if (ra == AW'(ZERO_REG)) begin
                val = '0;
            end
            data_readReg[r*WIDTH +: WIDTH] = val;
        end
    end

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_WR (NUM_WR),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clock           (clock),
        .ctrl_reset_n    (ctrl_reset_n),
        .ctrl_writeEn    (ctrl_writeEn),
        .ctrl_writeReg   (ctrl_writeReg),
        .ctrl_reserveEn  (ctrl_reserveEn),
        .ctrl_reserveReg (ctrl_reserveReg),
        .ctrl_readReg    (ctrl_readReg),
        .status_busy     (status_busy),
        .status_anyBusy  (status_anyBusy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
//   Self-checking bench for regfile_mp (32x32, 2 read ports, 2 write ports).
//   Expected values come from a small reference model of the register file
//   and busy bits, plus fixed constants for the key scenarios. Expectations
//   are queued when stimulus is driven and compared at the falling edge.
//   Honours WR_BYPASS_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;

    logic          clock;
    logic          rst_n;
    logic [1:0]    we;
    logic [2*AW-1:0] wreg;
    logic [2*W-1:0]  wdata;
    logic [2*AW-1:0] rreg;
    logic [2*W-1:0]  rdata;
    logic          res_en;
    logic [AW-1:0] res_reg;
    logic [1:0]    busy;
    logic          any_busy;

    regfile_mp #(
        .WIDTH  (W),
        .DEPTH  (D),
        .NUM_RD (2),
        .NUM_WR (2)
    ) dut (
        .clock           (clock),
        .ctrl_reset_n    (rst_n),
        .ctrl_writeEn    (we),
        .ctrl_writeReg   (wreg),
        .data_writeReg   (wdata),
        .ctrl_readReg    (rreg),
        .data_readReg    (rdata),
        .ctrl_reserveEn  (res_en),
        .ctrl_reserveReg (res_reg),
        .status_busy     (busy),
        .status_anyBusy  (any_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model
    logic [W-1:0] mdl [D];
    logic         busy_m [D];

    typedef struct {
        int          kind;   // 0/1 read data port, 2/3 busy port, 4 anyBusy
        logic [W-1:0] exp;
        string       tag;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] observe(input int kind);
        case (kind)
            0:       return rdata[W-1:0];
            1:       return rdata[2*W-1:W];
            2:       return {31'd0, busy[0]};
            3:       return {31'd0, busy[1]};
            default: return {31'd0, any_busy};
        endcase
    endfunction

    task automatic push(input int kind, input logic [W-1:0] exp, input string tag);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.tag  = tag;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.kind), e.exp);
        end
    endtask

    function automatic logic [W-1:0] exp_read(input logic [AW-1:0] a);
        logic [W-1:0] v;
        v = mdl[a];
`ifdef WR_BYPASS_EN
        if (we[0] && wreg[AW-1:0] == a) v = wdata[W-1:0];
        if (we[1] && wreg[2*AW-1:AW] == a) v = wdata[2*W-1:W];
`endif
        if (a == '0) v = '0;
        return v;
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        logic b;
        b = busy_m[a];
`ifdef WR_BYPASS_EN
        if (((we[0] && wreg[AW-1:0] == a) || (we[1] && wreg[2*AW-1:AW] == a))
            && !(res_en && res_reg == a)) b = 1'b0;
`endif
        return b;
    endfunction

    function automatic logic exp_any();
        logic b;
        b = 1'b0;
        for (int i = 0; i < D; i++) b = b | busy_m[i];
        return b;
    endfunction

    task automatic expect_all(input string tag);
        push(0, exp_read(rreg[AW-1:0]), {tag, "_rd0"});
        push(1, exp_read(rreg[2*AW-1:AW]), {tag, "_rd1"});
        push(2, {31'd0, exp_busy(rreg[AW-1:0])}, {tag, "_busy0"});
        push(3, {31'd0, exp_busy(rreg[2*AW-1:AW])}, {tag, "_busy1"});
        push(4, {31'd0, exp_any()}, {tag, "_any"});
    endtask

    task automatic model_clear();
        for (int i = 0; i < D; i++) begin
            mdl[i]    = '0;
            busy_m[i] = 1'b0;
        end
    endtask

    task automatic model_update();
        logic [AW-1:0] a;
        if (rst_n) begin
            for (int p = 0; p < 2; p++) begin
                a = wreg[p*AW +: AW];
                if (we[p] && a != '0) begin
                    mdl[a]    = wdata[p*W +: W];
                    busy_m[a] = 1'b0;
                end
            end
            if (res_en && res_reg != '0) busy_m[res_reg] = 1'b1;
        end
    endtask

    // Compare queued expectations at the falling edge, then let the rising
    // edge commit the driven cycle; inputs change 1 time unit after it.
    task automatic step();
        @(negedge clock);
        drain();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic idle();
        we      = '0;
        wreg    = '0;
        wdata   = '0;
        res_en  = 1'b0;
        res_reg = '0;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [W-1:0] d);
        we[p]            = 1'b1;
        wreg[p*AW +: AW] = a;
        wdata[p*W +: W]  = d;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rreg = {a1, a0};
    endtask

    task automatic reserve(input logic [AW-1:0] a);
        res_en  = 1'b1;
        res_reg = a;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        idle();
        rst_n = 1'b0;
        set_rd(5'd0, 5'd5);
        #2;
        // Outputs while in reset
        expect_all("rst");
        push(1, 32'h0, "rst_r5");
        drain();
        @(posedge clock);
        #1;
        rst_n = 1'b1;

        // 1: write 0000DEAD everywhere, read back on both ports
        for (int i = 0; i < D; i++) begin
            idle();
            set_wr(0, 5'(i), 32'h0000_DEAD);
            set_rd(5'(i), 5'(i));
            expect_all("t1_wr");
            step();
        end
        idle();
        for (int i = 0; i < D; i++) begin
            set_rd(5'(i), 5'(D - 1 - i));
            push(0, (i == 0) ? 32'h0 : 32'h0000_DEAD, "t1_rd0");
            push(1, (i == D - 1) ? 32'h0 : 32'h0000_DEAD, "t1_rd1");
            expect_all("t1_rd");
            step();
        end

        // 2: write-write collision, port 1 wins
        idle();
        set_wr(0, 5'd5, 32'h0000_1111);
        set_wr(1, 5'd5, 32'h0000_2222);
        set_rd(5'd5, 5'd5);
        expect_all("t2_wr");
        step();
        idle();
        push(0, 32'h0000_2222, "t2_r5");
        expect_all("t2_rd");
        step();

        // 3: same-cycle write and read of r7, from a clean reset
        @(negedge clock);
        rst_n = 1'b0;
        model_clear();
        #1;
        rst_n = 1'b1;
        @(posedge clock);
        #1;
        idle();
        set_wr(0, 5'd7, 32'h0000_CAFE);
        set_rd(5'd7, 5'd7);
`ifdef WR_BYPASS_EN
        push(0, 32'h0000_CAFE, "t3_same");
`else
        push(0, 32'h0, "t3_same");
`endif
        expect_all("t3_wr");
        step();
        idle();
        push(0, 32'h0000_CAFE, "t3_next");
        push(1, 32'h0000_CAFE, "t3_next1");
        step();

        // 4: scoreboard set / clear / reserve-wins
        idle();
        reserve(5'd9);
        set_rd(5'd9, 5'd0);
        push(2, 32'h0, "t4_pre");
        expect_all("t4_rsv");
        step();
        idle();
        push(2, 32'h1, "t4_busy");
        push(4, 32'h1, "t4_any");
        step();
        set_wr(0, 5'd9, 32'h0000_0099);
        expect_all("t4_wr");
        step();
        idle();
        push(2, 32'h0, "t4_clr");
        push(4, 32'h0, "t4_anyclr");
        step();
        set_wr(1, 5'd9, 32'h0000_0909);
        reserve(5'd9);
        expect_all("t4_rsvwr");
        step();
        idle();
        push(2, 32'h1, "t4_rsvwins");
        push(0, 32'h0000_0909, "t4_data");
        step();

        // 5: reserve and write of r0 are ignored
        set_wr(0, 5'd9, 32'h0000_0001);
        step();
        idle();
        reserve(5'd0);
        set_rd(5'd0, 5'd9);
        step();
        idle();
        push(2, 32'h0, "t5_busy0");
        push(4, 32'h0, "t5_any");
        expect_all("t5_rsv0");
        step();
        set_wr(0, 5'd0, 32'hFFFF_FFFF);
        set_wr(1, 5'd0, 32'hFFFF_FFFF);
        push(0, 32'h0, "t5_r0_same");
        step();
        idle();
        push(0, 32'h0, "t5_r0");
        expect_all("t5_rd");
        step();

        // 6: fill, reserve, then asynchronous reset mid-cycle
        for (int i = 1; i < D; i++) begin
            idle();
            set_wr(0, 5'(i), 32'hA500_0000 | 32'(i));
            set_rd(5'(i), 5'(i - 1));
            expect_all("t6_fill");
            step();
        end
        idle();
        reserve(5'd3);
        step();
        idle();
        set_rd(5'd3, 5'd17);
        push(0, 32'hA500_0003, "t6_pre3");
        push(2, 32'h1, "t6_prebusy");
        step();
        set_wr(0, 5'd4, 32'h0000_0123);
        reserve(5'd20);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        push(0, 32'h0, "t6_rst_rd3");
        push(1, 32'h0, "t6_rst_rd17");
        push(2, 32'h0, "t6_rst_busy");
        push(4, 32'h0, "t6_rst_any");
        drain();
        // The write/reserve stays driven across an edge while in reset
        @(posedge clock);
        model_update();
        #1;
        rst_n = 1'b1;
        idle();
        set_rd(5'd4, 5'd20);
        push(0, 32'h0, "t6_lost_wr");
        push(3, 32'h0, "t6_lost_rsv");
        expect_all("t6_after");
        step();

        // Random mixed traffic against the model
        for (int n = 0; n < 300; n++) begin
            we      = 2'($urandom_range(0, 3));
            wreg    = 10'($urandom);
            wdata   = {$urandom, $urandom};
            res_en  = ($urandom_range(0, 3) == 0);
            res_reg = 5'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                set_rd(wreg[AW-1:0], 5'($urandom));
            end else begin
                set_rd(5'($urandom), wreg[2*AW-1:AW]);
            end
            expect_all("rnd");
            step();
        end
        idle();
        @(negedge clock);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
